// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: fetches sequential words over a request/ack
// handshake into a circular buffer and hands the head entry to the IF stage.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        out_IMemRequest,
    output logic [31:0] out_IMemAddress,
    input  logic        in_IMemAck,
    input  logic [31:0] in_IMemData,
    input  logic        in_BranchValid,
    input  logic [31:0] in_BranchTarget,
    input  logic        in_IFCanGo,
    output logic        out_IFOwnCanGo,
    output logic [31:0] out_Instruction,
    output logic [31:0] out_InstructionAddress
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DROP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [31:0]        pc;
    logic [31:0]        pc_next;
    logic [31:0]        drop_addr;
    logic [31:0]        drop_addr_next;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic [31:0]        addr_mem [DEPTH];
    logic [31:0]        data_mem [DEPTH];

    logic        ack;
    logic        push;
    logic        pop;
    logic        flush;
    logic [31:0] target;
    logic        unused_target_lsbs;

    assign target             = {in_BranchTarget[31:2], 2'b00};
    assign unused_target_lsbs = ^in_BranchTarget[1:0];

    assign out_IMemRequest = (state == S_BUSY) || (state == S_DROP);
    assign ack             = in_IMemAck && out_IMemRequest;
    assign flush           = in_BranchValid;
    // A redirect wins over everything: nothing enters or leaves the buffer that cycle.
    assign push            = (state == S_BUSY) && ack && !flush;
    assign pop             = in_IFCanGo && out_IFOwnCanGo && !flush;

    assign out_IFOwnCanGo         = (count != '0);
    assign out_Instruction        = out_IFOwnCanGo ? data_mem[rd_ptr] : 32'h0;
    assign out_InstructionAddress = out_IFOwnCanGo ? addr_mem[rd_ptr] : 32'h0;

    always_comb begin
        unique case (state)
            S_BUSY:  out_IMemAddress = pc;
            S_DROP:  out_IMemAddress = drop_addr;
            default: out_IMemAddress = 32'h0;
        endcase
    end

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case statement can leave one unassigned (latch).
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        drop_addr_next = drop_addr;
        unique case (state)
            S_IDLE: begin
                if (flush) begin
                    pc_next = target;
                end else if (count < FULL) begin
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    pc_next = target;
                    if (ack) begin
                        state_next = S_IDLE;
                    end else begin
                        // The memory still owes a response for the old address.
                        state_next     = S_DROP;
                        drop_addr_next = pc;
                    end
                end else if (ack) begin
                    pc_next    = pc + 32'd4;
                    state_next = (count_next < FULL) ? S_BUSY : S_IDLE;
                end
            end
            S_DROP: begin
                if (flush) begin
                    pc_next = target;
                end else if (ack) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            drop_addr <= 32'h0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            drop_addr <= drop_addr_next;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count_next;
            end
        end
    end

    // NOTE: the storage array has no reset; entries are only observable once
    // count says they were written, so clearing them would buy nothing.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[wr_ptr] <= pc;
            data_mem[wr_ptr] <= in_IMemData;
        end
    end

endmodule

// File: doc/if_prefetch_queue.md
# if_prefetch_queue

Instruction-fetch front end that feeds the pipeline's IF stage and supplies its own-can-go flag to the stall chain. It fetches sequential words from instruction memory over a request/acknowledge handshake, buffers up to DEPTH fetched instructions with their addresses, and releases the head entry whenever the stall chain's IF can-go is high. A branch redirect from EXE flushes the buffer and restarts fetch at the target, discarding any in-flight response.

## Interface
- DEPTH, 4: buffer entries, power of two, 2..16
- RESET_PC, 32'h0000_0000: first fetch address after reset
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- out_IMemRequest  out  1  fetch request, held until acknowledged
- out_IMemAddress  out  32  word address of the outstanding request
- in_IMemAck  in  1  response valid; sampled only while out_IMemRequest=1
- in_IMemData  in  32  instruction word, valid with in_IMemAck
- in_BranchValid  in  1  redirect strobe from EXE, one cycle
- in_BranchTarget  in  32  redirect address, bits[1:0] ignored (forced 0)
- in_IFCanGo  in  1  IF can-go from the stall chain; head is consumed when high
- out_IFOwnCanGo  out  1  buffer non-empty
- out_Instruction  out  32  head instruction; 0 when empty
- out_InstructionAddress  out  32  head address; 0 when empty

## Operation
- Storage: circular buffer of {address, instruction}, read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, count 0..DEPTH.
- Pop: in_IFCanGo & out_IFOwnCanGo → read pointer +1, count −1.
- FSM, registered state:
  - IDLE: no request. If count < DEPTH and no branch → BUSY.
  - BUSY: request high at fetch PC. On ack without branch: push {PC, data}, PC += 4; stay BUSY if post-update count < DEPTH (including a same-cycle pop), else IDLE. No ack: hold request and address.
  - DROP: request high at the old address until ack; response discarded; on ack → IDLE.
- out_IMemRequest = (state == BUSY or DROP); out_IMemAddress = PC in BUSY, held in-flight address in DROP.
- Branch (highest priority, any state): buffer flushed (count 0, pointers reset); PC ← target & ~3; same-cycle pop and push suppressed.
  - IDLE + branch → IDLE.
  - BUSY + branch without ack → DROP.
  - BUSY + branch with ack → IDLE, data discarded.
  - DROP + branch → stays DROP; PC takes the newest target.
- Overflow is impossible: requests are only issued with a free slot reserved, and pops only free more.
- Address arithmetic is 32-bit; PC wraps from 32'hFFFF_FFFC to 0.

## Timing
- Reset (asynchronous assert, synchronous release at the next clock) sets: state IDLE, PC RESET_PC, count 0, and all outputs 0. Reset mid-request drops the request immediately; a later ack is ignored.
- The first request rises one cycle after reset release.
- With zero-wait memory (ack in the first request cycle), the buffer accepts one instruction per cycle. An entry pushed at edge N is visible at the head and sets out_IFOwnCanGo after edge N.
- Full: request drops the cycle after the DEPTH-th push. It re-rises one cycle after the pop that frees a slot.
- Branch at edge N: out_IFOwnCanGo = 0 after N. From IDLE or BUSY-with-ack, the request to the target rises after edge N+1. From DROP, it rises one cycle after the discarded ack.
- Head outputs are combinational from storage and the count; there are no combinational paths from in_IFCanGo to outputs.

## Test plan
- Reset with RESET_PC=0x100, zero-wait memory, in_IFCanGo=0 → requests at 0x100, 0x104, 0x108, 0x10C on consecutive cycles; request low thereafter; count 4; head = {0x100, data0}.
- Full buffer, then in_IFCanGo=1 for one cycle → head advances to 0x104; request to 0x110 one cycle later; no entry lost or duplicated.
- Memory with 3-cycle ack latency, branch to 0x2000 in the second wait cycle → address held; ack data discarded; next request at 0x2000; no stale entry appears.
- Branch to 0x3002 in the same cycle as ack and pop → buffer empty; next request at 0x3000; acked word absent.
- Continuous in_IFCanGo=1 with zero-wait memory → out_IFOwnCanGo stays high after the first push; addresses strictly sequential; PC wraps 0xFFFF_FFFC → 0.
- Reset asserted mid-request with a pending ack → outputs 0 immediately; after release, fetch restarts at RESET_PC.
